// File: rtl/pipe_cla_pkg.sv
// Shared constants, flag bundle and configuration check for the pipelined CLA adder/subtractor.
package pipe_cla_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // WIDTH must split into whole stages, and each stage into whole 4-bit groups.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (chunk % 4 == 0) && (width >= chunk) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate and carry-out.
module cla_group4
  import pipe_cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       g,
  output logic       p,
  output logic       co
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  assign c[0] = ci;
  assign c[1] = gi[0] | (pi[0] & ci);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);

  assign g  = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p  = &pi;
  assign co = g | (p & ci);
  assign s  = pi ^ c;

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined CLA adder/subtractor: one CHUNK-bit stage per cycle, carry registered between stages.
// Optional PIPE_CLA_SAT_EN: saturate the result on signed overflow instead of wrapping.
module pipe_cla_addsub
  import pipe_cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned LAT  = WIDTH / CHUNK;
  localparam int unsigned NGRP = CHUNK / 4;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_cla_addsub: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
  end

  logic             advance;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic             fin_v;
  logic             msb_ci;
  logic             msb_co;
  logic [WIDTH-1:0] fin_sum;
  flags_t           fin_flg;
  flags_t           flg_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign bx       = (sub == OP_ADD) ? b : ~b;
  assign c0       = (sub == OP_SUB) ? 1'b1 : cin;

  // Stage k resolves bits [k*CHUNK +: CHUNK]; upper operand bits travel along (skew),
  // finished lower sum bits accumulate alongside (deskew).
  for (genvar k = 0; k < LAT; k++) begin : g_st
    localparam int unsigned RW = WIDTH - k * CHUNK;

    logic [RW-1:0]          ua;
    logic [RW-1:0]          ub;
    logic [(k+1)*CHUNK-1:0] s_nxt;
    logic [CHUNK-1:0]       cs;
    logic                   ci;
    logic                   vi;
    logic [NGRP:0]          gc;
    logic [NGRP-1:0]        gg;
    logic [NGRP-1:0]        gp;
    logic [NGRP-1:0]        gco;

    if (k == 0) begin : g_in
      assign ua    = a;
      assign ub    = bx;
      assign ci    = c0;
      assign vi    = in_valid;
      assign s_nxt = cs;
    end else begin : g_in
      assign ua    = g_st[k-1].g_reg.a_q;
      assign ub    = g_st[k-1].g_reg.b_q;
      assign ci    = g_st[k-1].g_reg.c_q;
      assign vi    = g_st[k-1].g_reg.v_q;
      assign s_nxt = {cs, g_st[k-1].g_reg.s_q};
    end

    assign gc[0] = ci;
    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      cla_group4 u_grp (
        .a  (ua[4*j +: 4]),
        .b  (ub[4*j +: 4]),
        .ci (gc[j]),
        .s  (cs[4*j +: 4]),
        .g  (gg[j]),
        .p  (gp[j]),
        .co (gco[j])
      );
      assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    // Group-level lookahead and each group's own carry-out must agree.
    always_comb begin
      assert (gco == gc[NGRP:1]) else $error("cla group carry-out disagrees with lookahead");
    end

    if (k < LAT - 1) begin : g_reg
      logic                   v_q;
      logic                   c_q;
      logic [(k+1)*CHUNK-1:0] s_q;
      logic [RW-CHUNK-1:0]    a_q;
      logic [RW-CHUNK-1:0]    b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          s_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          v_q <= vi;
          c_q <= gc[NGRP];
          s_q <= s_nxt;
          a_q <= ua[RW-1:CHUNK];
          b_q <= ub[RW-1:CHUNK];
        end
      end
    end
  end

  assign fin_v  = g_st[LAT-1].vi;
  assign msb_co = g_st[LAT-1].gc[NGRP];
  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
  assign msb_ci = g_st[LAT-1].s_nxt[WIDTH-1] ^ g_st[LAT-1].ua[CHUNK-1] ^ g_st[LAT-1].ub[CHUNK-1];

  always_comb begin
    fin_flg      = '0;
    fin_sum      = g_st[LAT-1].s_nxt;
    fin_flg.cout = msb_co;
    fin_flg.ovf  = msb_ci ^ msb_co;
`ifdef PIPE_CLA_SAT_EN
    // On overflow both operand signs match; their sign picks the rail.
    if (fin_flg.ovf) begin
      fin_sum = g_st[LAT-1].ua[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    fin_flg.zero = (fin_sum == '0);
  end

  // Output register; bubbles present zeros so idle operand values never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      flg_q     <= '0;
    end else if (advance) begin
      out_valid <= fin_v;
      sum       <= fin_v ? fin_sum : '0;
      flg_q     <= fin_v ? fin_flg : '0;
    end
  end

  assign cout = flg_q.cout;
  assign ovf  = flg_q.ovf;
  assign zero = flg_q.zero;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Randomized self-checking bench for pipe_cla_addsub against an arithmetic reference model.
module tb_pipe_cla_addsub;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int total = 0;
  int bad   = 0;
  int npop  = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          adv;
  } item_t;

  item_t q[$];
  item_t m_it;
  logic  m_ev;
  logic  m_adv;

  pipe_cla_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, overflow judged on the true signed result.
  function automatic item_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic sb);
    item_t       it;
    longint      sx;
    longint      sy;
    longint      r;
    logic [32:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      u = {1'b0, x} + {1'b0, ~y} + 33'd1;
      r = sx - sy;
    end else begin
      u = {1'b0, x} + {1'b0, y} + 33'(ci);
      r = sx + sy + longint'(ci);
    end
    it.c   = u[32];
    it.o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    it.s   = u[31:0];
`ifdef PIPE_CLA_SAT_EN
    if (it.o) it.s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    it.z   = (it.s == 32'h0);
    it.adv = 0;
    return it;
  endfunction

  // Single compare process: each accepted op must surface after LAT advancing cycles.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_sum", sum, 32'h0);
    end else begin
      m_ev = (q.size() > 0) && (q[0].adv == LAT);
      chk("out_valid", 32'(out_valid), 32'(m_ev));
      chk("in_ready", 32'(in_ready), 32'(!m_ev || out_ready));
      if (m_ev && out_valid) begin
        chk("sum", sum, q[0].s);
        chk("cout", 32'(cout), 32'(q[0].c));
        chk("ovf", 32'(ovf), 32'(q[0].o));
        chk("zero", 32'(zero), 32'(q[0].z));
      end
      m_adv = !m_ev || out_ready;
      if (m_adv) begin
        if (m_ev) begin
          void'(q.pop_front());
          npop++;
        end
        foreach (q[i]) q[i].adv++;
        if (in_valid) begin
          m_it     = model(a, b, cin, sub);
          m_it.adv = 1;
          q.push_back(m_it);
        end
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] x, input logic [31:0] y, input logic ci,
                     input logic sb, input logic [31:0] es, input logic ec, input logic eo,
                     input logic ez);
    item_t it;
    it = model(x, y, ci, sb);
    chk({nm, "_model_sum"}, it.s, es);
    chk({nm, "_model_flags"}, {29'h0, it.c, it.o, it.z}, {29'h0, ec, eo, ez});
  endtask

  task automatic direct(input string nm, input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sb, input logic [31:0] es, input logic ec, input logic eo,
                        input logic ez);
    int n;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(LAT));
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_flags"}, {29'h0, cout, ovf, zero}, {29'h0, ec, eo, ez});
  endtask

  task automatic drain(input string nm);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drained"}, 32'(q.size()), 32'h0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   idx;
    int   c;
    int   p0;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {27'h0, out_valid, cout, ovf, zero, 1'b0}, 32'h0);
    chk("reset_sum", sum, 32'h0);
    rst = 1'b0;

    pin("p_add_ff", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    pin("p_sub_57", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    direct("add_ff", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    direct("add_carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    direct("sub_5_7", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CLA_SAT_EN
    direct("sub_min_1", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    direct("add_max_1", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
    direct("sub_min_1", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    direct("add_max_1", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
    drain("directs");

    // Back-to-back adds with the consumer stalling on cycles 3..6.
    idx = 0; c = 0; p0 = npop;
    while (idx < 8 && c < 40) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid = 1'b1; a = 32'(idx); b = 32'h10; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      acc = in_ready;
      if (c == 5) chk("stall_in_ready", 32'(acc), 32'h0);
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    drain("stall");
    chk("stall_result_count", 32'(npop - p0), 32'd8);

    // Random traffic with random backpressure.
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      a = rand_op(); b = rand_op();
      cin = 1'($urandom); sub = 1'($urandom);
    end
    drain("random");

    // Three ops in flight, head one presented and stalled, then reset.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h100 + 32'(i); b = 32'h22; cin = 1'b1; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'h0);
    chk("async_reset_sum", sum, 32'h0);
    chk("async_reset_flags", {29'h0, cout, ovf, zero}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    direct("after_reset", 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
